output_buffer_ctrl: RTL and testbench
=====================================

# output_buffer_ctrl

Sequencer for the output buffer. It snapshots the thermometer codes of all sense columns, then time-multiplexes one shared thermometer-to-count encoder across the columns, one column per cycle. It packs the per-column counts plus their total into a result word and presents that word on a valid/ready handshake to the downstream bus interface. It sits between the comparator-bank thermometer outputs and the peripheral's result register path.

## Interface
- NUM_COL, 8: number of columns sequenced; ≥2, power of two.
- THERM_W, 8: thermometer bits per column.
- CNT_W, 4: count width; must satisfy 2^CNT_W > THERM_W.
- SUM_W, CNT_W+$clog2(NUM_COL): total-count width; derived, not overridden.
- clk_i  in  1  single clock, all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request a conversion frame; sampled only in IDLE.
- therm_i  in  NUM_COL*THERM_W  column thermometer codes; column k in bits [k*THERM_W +: THERM_W].
- busy_o  out  1  high in every state except IDLE.
- valid_o  out  1  result available.
- ready_i  in  1  downstream accepts result.
- data_o  out  NUM_COL*CNT_W  per-column counts; column k in bits [k*CNT_W +: CNT_W].
- sum_o  out  SUM_W  sum of all column counts.
- err_o  out  1  frame contained at least one non-thermometer code (see Configuration).

## Operation
- FSM states: IDLE, ENCODE, VALID.
- IDLE: if start_i, register therm_i into snapshot, clear data/sum/err accumulators, col_idx←0, go ENCODE. Otherwise stay.
- ENCODE: encoder sees snapshot column col_idx. At each edge, write its count into data slot col_idx, add it to the sum accumulator, and OR its invalid flag into err. If col_idx==NUM_COL-1, go VALID, else col_idx+1.
- VALID: valid_o=1, and data_o/sum_o/err_o are held stable. valid_o&ready_i → IDLE at the next edge. valid_o never drops without ready_i.
- Encoding: a legal code is MSB-first contiguous ones (8'b11100000→3, 8'h00→0, 8'hFF→8). Any other pattern is invalid, and its count is 0.
- start_i outside IDLE is ignored and not queued. This includes the handshake cycle.
- therm_i changes after the snapshot do not affect the frame.
- Outputs data_o, sum_o and err_o hold the last frame in IDLE. They are cleared when the next frame is accepted.

## Timing
- Reset (any state, mid-frame included): state IDLE, busy_o=0, valid_o=0, data_o=0, sum_o=0, err_o=0, col_idx=0. Any partial frame is discarded.
- start_i high in cycle 0 in IDLE → busy_o high from cycle 1. ENCODE occupies cycles 1..NUM_COL. valid_o is high from cycle NUM_COL+1 (cycle 9 by default).
- With ready_i held high, the result is accepted in cycle NUM_COL+1 and busy_o is low in cycle NUM_COL+2. The minimum frame period is NUM_COL+2 cycles.
- rst_i takes priority over start_i and ready_i in the same cycle.

## Configuration
- OUTPUT_BUFFER_CTRL_ERR_EN defined: the encoder produces an invalid flag, err_o reports it per frame, and invalid codes yield count 0.
- Not defined: no validity check. Invalid codes still encode to 0 through the default path. err_o is tied 0. The port list is unchanged.

## Structure
- Shared package output_buffer_pkg holds:
  - the FSM state enum;
  - default NUM_COL, THERM_W and CNT_W localparams;
  - a function computing SUM_W.
- Sub-module therm_count_encoder: combinational THERM_W→CNT_W count plus invalid flag. It is instantiated once and shared across columns.

## Test plan
- Reset, then one frame: snapshot columns 0..7 = 00,80,C0,E0,F0,F8,FC,FE with ready_i=1.
  - data_o = counts 0..7 (column k → k).
  - sum_o = 28, err_o = 0.
  - valid_o rises exactly 9 cycles after start_i.
- All columns FF with ready_i held low for 5 cycles.
  - Each column = 8, sum_o = 64.
  - valid_o and data stay stable until ready_i, then IDLE next cycle.
- Column 3 = 8'b10100000, others F0, macro defined.
  - Column 3 count = 0, sum_o = 28, err_o = 1.
  - The next clean frame clears err_o.
- Change therm_i every cycle during ENCODE.
  - Result matches the start-cycle snapshot only.
- start_i pulsed during ENCODE and in the handshake cycle.
  - Both are ignored; exactly one frame completes.
- Assert rst_i in the 4th ENCODE cycle.
  - All outputs return to 0 and the FSM returns to IDLE.
  - A new start_i produces a correct frame.

Source files
------------

// File: rtl/output_buffer_pkg.sv
// Shared types and default sizing for the output buffer sequencer.
package output_buffer_pkg;

  localparam int unsigned NUM_COL_DEF = 8;
  localparam int unsigned THERM_W_DEF = 8;
  localparam int unsigned CNT_W_DEF   = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENCODE = 2'd1,
    S_VALID  = 2'd2
  } state_e;

  // Width of the frame total: per-column count plus headroom for NUM_COL additions.
  function automatic int unsigned sum_width(input int unsigned num_col, input int unsigned cnt_w);
    return cnt_w + $clog2(num_col);
  endfunction

endpackage

// File: rtl/therm_count_encoder.sv
// Combinational thermometer-to-count encoder; legal codes are MSB-first contiguous ones.
// Invalid flag is only produced when OUTPUT_BUFFER_CTRL_ERR_EN is defined.
module therm_count_encoder #(
  parameter int unsigned THERM_W = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic [THERM_W-1:0] therm_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               invalid_o
);

  logic [THERM_W-1:0] all_ones;
  logic [THERM_W-1:0] mask;
  logic               legal;

  assign all_ones = '1;

  // Match against every legal pattern; anything unmatched falls through to count 0.
  always_comb begin
    count_o = '0;
    legal   = 1'b0;
    mask    = '0;
    for (int k = 0; k <= int'(THERM_W); k++) begin
      mask = ~(all_ones >> k);
      if (therm_i == mask) begin
        count_o = CNT_W'(k);
        legal   = 1'b1;
      end
    end
  end

`ifdef OUTPUT_BUFFER_CTRL_ERR_EN
  assign invalid_o = ~legal;
`else
  assign invalid_o = 1'b0;
`endif

endmodule

// File: rtl/output_buffer_ctrl.sv
// Output buffer sequencer: snapshots all column codes, encodes one column per cycle
// through a shared encoder, then offers counts and total on valid/ready.
// Error reporting enabled by defining OUTPUT_BUFFER_CTRL_ERR_EN.
module output_buffer_ctrl
  import output_buffer_pkg::*;
#(
  parameter int unsigned NUM_COL = NUM_COL_DEF,
  parameter int unsigned THERM_W = THERM_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [NUM_COL*THERM_W-1:0] therm_i,
  output logic                       busy_o,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [NUM_COL*CNT_W-1:0]   data_o,
  output logic [sum_width(NUM_COL, CNT_W)-1:0] sum_o,
  output logic                       err_o
);

  localparam int unsigned SUM_W = sum_width(NUM_COL, CNT_W);
  localparam int unsigned IDX_W = $clog2(NUM_COL);

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           col_idx_q, col_idx_d;
  logic [NUM_COL*THERM_W-1:0] snap_q, snap_d;
  logic [NUM_COL*CNT_W-1:0]   data_q, data_d;
  logic [SUM_W-1:0]           sum_q, sum_d;
  logic                       err_q, err_d;
  logic                       busy_q, busy_d;
  logic                       valid_q, valid_d;

  logic [THERM_W-1:0]         enc_therm;
  logic [CNT_W-1:0]           enc_count;
  logic                       enc_invalid;

  assign enc_therm = snap_q[col_idx_q*THERM_W +: THERM_W];

  therm_count_encoder #(
    .THERM_W (THERM_W),
    .CNT_W   (CNT_W)
  ) u_enc (
    .therm_i   (enc_therm),
    .count_o   (enc_count),
    .invalid_o (enc_invalid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      col_idx_q <= '0;
      snap_q    <= '0;
      data_q    <= '0;
      sum_q     <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      snap_q    <= snap_d;
      data_q    <= data_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    snap_d    = snap_q;
    data_d    = data_q;
    sum_d     = sum_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          snap_d    = therm_i;
          data_d    = '0;
          sum_d     = '0;
          err_d     = 1'b0;
          col_idx_d = '0;
          state_d   = S_ENCODE;
        end
      end
      S_ENCODE: begin
        data_d[col_idx_q*CNT_W +: CNT_W] = enc_count;
        sum_d = sum_q + SUM_W'(enc_count);
        err_d = err_q | enc_invalid;
        if (col_idx_q == IDX_W'(NUM_COL - 1)) begin
          state_d = S_VALID;
        end else begin
          col_idx_d = col_idx_q + IDX_W'(1);
        end
      end
      S_VALID: begin
        if (ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered from the next state so they align with it.
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_VALID);
  end

  assign busy_o  = busy_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sum_o   = sum_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Self-checking bench for output_buffer_ctrl: directed vector table, corner sequences
// and randomized frames checked against a behavioural model.
module tb_output_buffer_ctrl;

  localparam int NUM_COL = 8;
  localparam int THERM_W = 8;
  localparam int CNT_W   = 4;
  localparam int SUM_W   = 7;

`ifdef OUTPUT_BUFFER_CTRL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                       clk;
  logic                       rst_i;
  logic                       start_i;
  logic [NUM_COL*THERM_W-1:0] therm_i;
  logic                       busy_o;
  logic                       valid_o;
  logic                       ready_i;
  logic [NUM_COL*CNT_W-1:0]   data_o;
  logic [SUM_W-1:0]           sum_o;
  logic                       err_o;

  int n_vec = 0;
  int n_err = 0;

  output_buffer_ctrl dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .therm_i (therm_i),
    .busy_o  (busy_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .sum_o   (sum_o),
    .err_o   (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] therm;
    int          rdy_dly;
    logic [31:0] exp_data;
    logic [6:0]  exp_sum;
    bit          exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: count leading ones; any one after the first zero makes the code illegal (count 0).
  function automatic void model(input logic [63:0] codes, output logic [31:0] d,
                                output logic [6:0] s, output bit e);
    logic [7:0] c;
    int n;
    bit gap, bad;
    d = '0; s = '0; e = 1'b0;
    for (int k = 0; k < NUM_COL; k++) begin
      c = codes[k*8 +: 8];
      n = 0; gap = 1'b0; bad = 1'b0;
      for (int b = 7; b >= 0; b--) begin
        if (c[b]) begin
          if (gap) bad = 1'b1;
          else n++;
        end else begin
          gap = 1'b1;
        end
      end
      if (bad) n = 0;
      d[k*4 +: 4] = 4'(n);
      s = s + 7'(n);
      e = e | (bad & ERR_EN);
    end
  endfunction

  // Runs one frame starting in IDLE just after a clock edge.
  task automatic run_frame(input logic [63:0] codes, input int rdy_dly, input bit scramble,
                           input bit poke, input logic [31:0] exp_data,
                           input logic [6:0] exp_sum, input bit exp_err);
    int lat;
    therm_i = codes;
    start_i = 1'b1;
    ready_i = 1'b0;
    step();
    start_i = 1'b0;
    check("busy_rise", 64'(busy_o), 64'd1);
    check("sum_cleared", 64'(sum_o), 64'd0);
    check("err_cleared", 64'(err_o), 64'd0);
    lat = 1;
    while (!valid_o && lat < 20) begin
      if (scramble) therm_i = {$urandom, $urandom};
      if (poke) start_i = (lat == 3);
      step();
      lat++;
    end
    start_i = 1'b0;
    check("valid_latency", 64'(lat), 64'(NUM_COL + 1));
    for (int i = 0; i < rdy_dly; i++) begin
      step();
      check("stall_valid", 64'(valid_o), 64'd1);
      check("stall_data", 64'(data_o), 64'(exp_data));
    end
    check("data", 64'(data_o), 64'(exp_data));
    check("sum", 64'(sum_o), 64'(exp_sum));
    check("err", 64'(err_o), 64'(exp_err));
    ready_i = 1'b1;
    if (poke) start_i = 1'b1;
    step();
    ready_i = 1'b0;
    start_i = 1'b0;
    check("idle_valid", 64'(valid_o), 64'd0);
    check("idle_busy", 64'(busy_o), 64'd0);
    check("idle_hold_data", 64'(data_o), 64'(exp_data));
    check("idle_hold_sum", 64'(sum_o), 64'(exp_sum));
    step();
    check("no_queued_start", 64'(busy_o), 64'd0);
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] ff;
    int n;
    ff = 8'hFF;
    if ($urandom_range(0, 3) == 0) return 8'($urandom);
    n = int'($urandom_range(0, 8));
    return ~(ff >> n);
  endfunction

  initial begin
    logic [63:0] codes;
    logic [31:0] md;
    logic [6:0]  ms;
    bit          me;

    vecs[0] = '{64'hFEFC_F8F0_E0C0_8000, 0, 32'h7654_3210, 7'd28, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 5, 32'h8888_8888, 7'd64, 1'b0};
    vecs[2] = '{64'hF0F0_F0F0_A0F0_F0F0, 0, 32'h4444_0444, 7'd28, ERR_EN};
    vecs[3] = '{64'h0000_0000_0000_0000, 1, 32'h0000_0000, 7'd0,  1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FF01, 2, 32'h8888_8880, 7'd56, ERR_EN};

    // Reset with start held high: reset must win.
    rst_i = 1'b1; start_i = 1'b1; ready_i = 1'b1; therm_i = '1;
    step();
    step();
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_sum", 64'(sum_o), 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    rst_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    step();
    check("post_rst_idle", 64'(busy_o), 64'd0);

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].therm, vecs[i].rdy_dly, 1'b0, 1'b0,
                vecs[i].exp_data, vecs[i].exp_sum, vecs[i].exp_err);

    // Inputs scrambled during ENCODE; result must reflect the snapshot only.
    run_frame(vecs[0].therm, 0, 1'b1, 1'b0, vecs[0].exp_data, vecs[0].exp_sum, 1'b0);

    // Start pulses during ENCODE and in the handshake cycle are ignored.
    run_frame(vecs[2].therm, 1, 1'b0, 1'b1, vecs[2].exp_data, vecs[2].exp_sum, ERR_EN);

    // Reset in the 4th ENCODE cycle discards the partial frame.
    therm_i = 64'hFFFF_FFFF_FFFF_FF01;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    check("mid_frame_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_valid", 64'(valid_o), 64'd0);
    check("midrst_data", 64'(data_o), 64'd0);
    check("midrst_sum", 64'(sum_o), 64'd0);
    check("midrst_err", 64'(err_o), 64'd0);
    step();
    check("midrst_stay_idle", 64'(busy_o), 64'd0);
    run_frame(vecs[1].therm, 0, 1'b0, 1'b0, vecs[1].exp_data, vecs[1].exp_sum, 1'b0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 30; f++) begin
      for (int k = 0; k < NUM_COL; k++) codes[k*8 +: 8] = rand_code();
      model(codes, md, ms, me);
      run_frame(codes, int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), md, ms, me);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
